// File: rtl/snake_ps2_pkg.sv
// Shared types and defaults for the PS/2 keyboard front end of the snake game.
package snake_ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int PS2_FILTER_LEN_DEFAULT = 8;
  localparam int PS2_TIMEOUT_DEFAULT    = 200000;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus run-length glitch filter for the PS/2 clock line.
// Emits a one-cycle fall strobe when the filtered level goes high -> low.
module ps2_sync_filter
  import snake_ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_reg;
  logic          filt_reg;
  logic          filt_prev_reg;
  logic [CW-1:0] cnt_reg;

  // Idle bus is high, so everything resets to 1 to avoid a spurious fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg      <= 2'b11;
      filt_reg      <= 1'b1;
      filt_prev_reg <= 1'b1;
      cnt_reg       <= '0;
    end else begin
      sync_reg      <= {sync_reg[0], raw};
      filt_prev_reg <= filt_reg;
      if (sync_reg[1] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        filt_reg <= sync_reg[1];
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign fall = filt_prev_reg & ~filt_reg;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 frame receiver: 11-bit frames with odd parity, stop check and inter-bit
// timeout; keeps the two most recent scan-code bytes for the direction decoder.
module ps2_receiver
  import snake_ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        rx_done,
  output logic        frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t  state_reg, state_next;
  logic [1:0]  data_sync_reg;
  logic        data_bit;
  logic        clk_fall;
  logic        timeout;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        parity_reg, parity_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [15:0] keycode_reg, keycode_next;
  logic        rx_done_reg, rx_done_next;
  logic        frame_err_reg, frame_err_next;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_clk),
    .fall  (clk_fall)
  );

  assign data_bit = data_sync_reg[1];
  // A fall in the terminal-count cycle keeps the frame alive.
  assign timeout  = (state_reg != IDLE) && !clk_fall && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = IDLE;
    end else if (clk_fall) begin
      case (state_reg)
        IDLE:    if (!data_bit) state_next = DATA;
        DATA:    if (bit_cnt_reg == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    parity_next    = parity_reg;
    keycode_next   = keycode_reg;
    rx_done_next   = 1'b0;
    frame_err_next = 1'b0;
    to_cnt_next    = (state_reg == IDLE || clk_fall) ? '0 : to_cnt_reg + 1'b1;
    if (timeout) begin
      frame_err_next = 1'b1;
      to_cnt_next    = '0;
    end else if (clk_fall) begin
      case (state_reg)
        IDLE:   bit_cnt_next = 3'd0;
        DATA: begin
          shift_next   = {data_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
        end
        PARITY: parity_next = data_bit;
        STOP: begin
          if (data_bit && (^{shift_reg, parity_reg})) begin
            keycode_next = {keycode_reg[7:0], shift_reg};
            rx_done_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sync_reg <= 2'b11;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      to_cnt_reg    <= '0;
      keycode_reg   <= '0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      parity_reg    <= parity_next;
      to_cnt_reg    <= to_cnt_next;
      keycode_reg   <= keycode_next;
      rx_done_reg   <= rx_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign keycode   = keycode_reg;
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: table of frames plus hand-written
// reset, glitch and timeout sequences, checked through an expectation queue.
module tb_ps2_receiver;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 20;
  localparam int LAT  = 2 + FL + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        rx_done;
  logic        frame_err;

  ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_done;
    logic [15:0] kc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [7:0]  b;
    logic        par_ok;
    logic        stop;
    int          glitch_idx;
    logic        is_done;
    logic [15:0] kc;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   last_fall = 0;

  // Every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_done || frame_err) begin
      $display("rx: rx_done=%b frame_err=%b keycode=%h cyc=%0d", rx_done, frame_err, keycode, cyc);
      total++;
      if (rx_done && frame_err) begin
        bad++;
        $display("FAIL both_pulses rx_done=%b frame_err=%b required not both", rx_done, frame_err);
      end
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse rx_done=%b frame_err=%b keycode=%h required no pulse", rx_done, frame_err, keycode);
      end else begin
        cur = sb.pop_front();
        total++;
        if (rx_done !== cur.is_done) begin
          bad++;
          $display("FAIL pulse_kind rx_done=%b required=%b", rx_done, cur.is_done);
        end
        total++;
        if (keycode !== cur.kc) begin
          bad++;
          $display("FAIL keycode got=%h required=%h", keycode, cur.kc);
        end
        total++;
        if (cyc - last_fall !== cur.lat) begin
          bad++;
          $display("FAIL latency got=%0d required=%0d", cyc - last_fall, cur.lat);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic d, input logic [15:0] kc, input int lat);
    exp_t e;
    e.is_done = d;
    e.kc      = kc;
    e.lat     = lat;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      tick(5);
      ps2_clk = 1'b0;
      tick(FL - 1);
      ps2_clk = 1'b1;
      tick(HALF - 5 - (FL - 1));
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b0;
    last_fall = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int glitch_idx);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_idx);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      tick(1);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hE0, 1'b1, 1'b1, -1, 1'b1, 16'h00E0};
    vecs[1] = '{8'h72, 1'b1, 1'b1, -1, 1'b1, 16'hE072};
    vecs[2] = '{8'h6B, 1'b0, 1'b1, -1, 1'b0, 16'hE072};
    vecs[3] = '{8'h6B, 1'b1, 1'b0, -1, 1'b0, 16'hE072};
    vecs[4] = '{8'hF0, 1'b1, 1'b1, -1, 1'b1, 16'h72F0};
    vecs[5] = '{8'h1C, 1'b1, 1'b1, -1, 1'b1, 16'hF01C};
    vecs[6] = '{8'h29, 1'b1, 1'b1,  5, 1'b1, 16'h1C29};

    reset_dut();
    total++;
    if (keycode !== 16'h0000) begin bad++; $display("FAIL reset_keycode got=%h required=0000", keycode); end
    total++;
    if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_rx_done got=%b required=0", rx_done); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b required=0", frame_err); end

    expect_ev(1'b1, 16'h0075, LAT);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    drain("first_75");

    // Abort a frame during its 4th data bit (0x75 bits 0..2 = 1,0,1; bit 3 = 0).
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b0;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(10);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(20);
    total++;
    if (keycode !== 16'h0000) begin bad++; $display("FAIL keycode_in_reset got=%h required=0000", keycode); end
    reset = 1'b0;
    tick(20);
    expect_ev(1'b1, 16'h0075, LAT);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    drain("after_midframe_reset");

    reset_dut();
    for (int i = 0; i < 7; i++) begin
      expect_ev(vecs[i].is_done, vecs[i].kc, LAT);
      send_frame(vecs[i].b, vecs[i].par_ok ? ~^vecs[i].b : ^vecs[i].b, vecs[i].stop, vecs[i].glitch_idx);
      drain("table_vector");
    end

    // Truncated frame: start plus 4 data bits of 0x72, then silence.
    expect_ev(1'b0, 16'h1C29, LAT + TO);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    ps2_data = 1'b1;
    drain("timeout");
    tick(10);
    expect_ev(1'b1, 16'h2972, LAT);
    send_frame(8'h72, 1'b1, 1'b1, -1);
    drain("after_timeout");

    tick(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
